// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper:
// FSM state encodings and settle counter width.
package truth_table_sweeper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DONE   = 3'd3
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: loadable down-counter with a zero flag.
// Load wins over decrement; the count stops at zero.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked sweep of every input combination into a truth table.
// Optional self-check ports enabled by macro SWEEP_CHECK_EN.
import truth_table_sweeper_pkg::*;

module truth_table_sweeper #(
  parameter int N_IN       = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 y_in,
  output logic [N_IN-1:0]      abc_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out
`ifdef SWEEP_CHECK_EN
  ,
  input  logic [2**N_IN-1:0]   exp_table,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt
`endif
);

  localparam int T = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = '1;
  localparam logic [CNT_W-1:0] LOADV = CNT_W'(SETTLE_CYC - 1);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic            load;
  logic            dec;
  logic            cnt_zero;
  logic            last;

  assign last = (idx == LAST);

  always_comb begin
    load = 1'b0;
    dec  = 1'b0;
    unique case (state)
      ST_IDLE:   load = start;
      ST_SETTLE: dec  = 1'b1;
      ST_SAMPLE: load = !last;
      default:   load = 1'b0;
    endcase
  end

  settle_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (LOADV),
    .dec      (dec),
    .zero     (cnt_zero)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

`ifdef SWEEP_CHECK_EN
  logic [N_IN:0] miss;

  always_comb begin
    miss = '0;
    for (int i = 0; i < T; i++) begin
      miss = miss + {{N_IN{1'b0}}, table_out[i] ^ exp_table[i]};
    end
  end
`endif

  // abc_out moves in lockstep with idx so it always equals idx
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      abc_out   <= '0;
      table_out <= '0;
`ifdef SWEEP_CHECK_EN
      pass      <= 1'b0;
      err_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            table_out <= '0;
            idx       <= '0;
            abc_out   <= '0;
            state     <= ST_SETTLE;
`ifdef SWEEP_CHECK_EN
            pass      <= 1'b0;
            err_cnt   <= '0;
`endif
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          table_out[idx] <= y_in;
          if (last) begin
            state <= ST_DONE;
          end else begin
            idx     <= idx + N_IN'(1);
            abc_out <= idx + N_IN'(1);
            state   <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
`ifdef SWEEP_CHECK_EN
          pass    <= (table_out == exp_table);
          err_cnt <= miss;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: two instances
// (settle 1 and 3) checked against a table/latency model.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start [2];
  logic [7:0] func  [2];
  logic [2:0] abc   [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] tab   [2];
  logic       y     [2];
`ifdef SWEEP_CHECK_EN
  logic [7:0] expt  [2];
  logic       pass  [2];
  logic [3:0] errc  [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // the function under test is a lookup into a bench-chosen table
  assign y[0] = func[0][abc[0]];
  assign y[1] = func[1][abc[1]];

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(1)) u0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start[0]),
    .y_in      (y[0]),
    .abc_out   (abc[0]),
    .busy      (busy[0]),
    .done      (done[0]),
    .table_out (tab[0])
`ifdef SWEEP_CHECK_EN
    ,
    .exp_table (expt[0]),
    .pass      (pass[0]),
    .err_cnt   (errc[0])
`endif
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYC(3)) u1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start[1]),
    .y_in      (y[1]),
    .abc_out   (abc[1]),
    .busy      (busy[1]),
    .done      (done[1]),
    .table_out (tab[1])
`ifdef SWEEP_CHECK_EN
    ,
    .exp_table (expt[1]),
    .pass      (pass[1]),
    .err_cnt   (errc[1])
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // one full sweep; rep>0 re-pulses start after edge rep
  task automatic sweep(input int d, input logic [7:0] f,
                       input logic [7:0] mask, input int rep);
    int s, lat, done_at, dcount, bad;
    logic [2:0] ea;
    s = sc(d);
    lat = 8 * (s + 1) + 1;
    done_at = 0;
    dcount = 0;
    bad = 0;
    func[d] = f;
`ifdef SWEEP_CHECK_EN
    expt[d] = f ^ mask;
`endif
    start[d] = 1'b1;
    for (int n = 1; n <= lat + 4; n++) begin
      @(posedge clk);
      #1;
      start[d] = (n == rep);
      if (done[d] === 1'b1) begin
        dcount++;
        if (done_at == 0) done_at = n;
      end
      if (n <= lat && busy[d] !== 1'b1) bad++;
      if (n < lat) begin
        ea = 3'((n - 1) / (s + 1));
        if (abc[d] !== ea) bad++;
      end
    end
    chk($sformatf("latency_d%0d", d), done_at, lat);
    chk($sformatf("done_count_d%0d", d), dcount, 1);
    chk($sformatf("seq_busy_d%0d", d), bad, 0);
    chk($sformatf("table_d%0d", d), {24'd0, tab[d]}, {24'd0, f});
    chk($sformatf("idle_d%0d", d), {31'd0, busy[d]}, 0);
`ifdef SWEEP_CHECK_EN
    chk($sformatf("pass_d%0d", d), {31'd0, pass[d]},
        (mask == 8'd0) ? 1 : 0);
    chk($sformatf("errcnt_d%0d", d), {28'd0, errc[d]},
        $countones(mask));
`endif
  endtask

  task automatic reset_mid;
    int k;
    func[0] = 8'h96;
`ifdef SWEEP_CHECK_EN
    expt[0] = 8'h96;
`endif
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    k = 0;
    while (abc[0] !== 3'd4 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_idx4", {29'd0, abc[0]}, 4);
    reset_n = 1'b0;
    #1;
    chk("rst_abc", {29'd0, abc[0]}, 0);
    chk("rst_busy", {31'd0, busy[0]}, 0);
    chk("rst_table", {24'd0, tab[0]}, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_busy", {31'd0, busy[0]}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sweep(0, 8'h96, 8'h00, 0);
  endtask

  task automatic held_start(input logic [7:0] f);
    int d1, d2, nd, k;
    d1 = 0;
    d2 = 0;
    nd = 0;
    func[0] = f;
`ifdef SWEEP_CHECK_EN
    expt[0] = f;
`endif
    start[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done[0] === 1'b1) begin
        nd++;
        if (d1 == 0) d1 = n;
        else if (d2 == 0) d2 = n;
        chk("held_table", {24'd0, tab[0]}, {24'd0, f});
      end
    end
    start[0] = 1'b0;
    chk("held_first_done", d1, 17);
    chk("held_spacing", d2 - d1, 18);
    chk("held_done_count", nd, 2);
    k = 0;
    while (busy[0] !== 1'b0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("held_drain", {31'd0, busy[0]}, 0);
    chk("held_final_table", {24'd0, tab[0]}, {24'd0, f});
  endtask

  initial begin
    logic [7:0] f, m;
    int d, rep;
    reset_n = 1'b0;
    start = '{1'b0, 1'b0};
    func = '{8'h00, 8'h00};
`ifdef SWEEP_CHECK_EN
    expt = '{8'h00, 8'h00};
`endif
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset_abc", {29'd0, abc[i]}, 0);
      chk("reset_busy", {31'd0, busy[i]}, 0);
      chk("reset_done", {31'd0, done[i]}, 0);
      chk("reset_table", {24'd0, tab[i]}, 0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sweep(0, 8'h96, 8'h00, 0);
    sweep(0, 8'h96, 8'h01, 0);
    sweep(1, 8'hEA, 8'h00, 0);
    sweep(0, 8'h5A, 8'h00, 5);
    reset_mid();
    held_start(8'h3C);
    for (int it = 0; it < 10; it++) begin
      d = int'($urandom_range(0, 1));
      f = 8'($urandom);
      m = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      rep = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 14));
      sweep(d, f, m, rep);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
